// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch PC sequencer: prediction entries,
// sequencer FSM states and reset defaults.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pred_next;
        logic [31:0] pc4;
    } pred_entry_t;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HOLD,
        ST_REDIR
    } state_t;

endpackage

// File: rtl/next_pc_mux.sv
// 2:1 next-PC selector: sequential fall-through or predicted target.
module next_pc_mux #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] seq,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] next
);

    assign next = sel ? target : seq;

endmodule

// File: rtl/pc_sequencer_pred_queue.sv
// In-order circular FIFO of fetched branch predictions awaiting EX
// resolution; pointers carry an extra wrap bit to tell full from empty.
module pred_queue
    import pc_sequencer_pkg::*;
#(
    parameter int DEPTH = PQ_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t din,
    output pred_entry_t dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    pred_entry_t   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    assign do_pop  = pop & ~empty;
    // A full queue can still take a push when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: chooses PC+4 / predicted target / EX redirect each
// cycle and checks queued predictions against EX resolution.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PQ_DEPTH = PQ_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        bht_taken,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        is_branch,
    input  logic        ex_valid,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        pq_full,
    output logic        mispredict
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc4;
    logic [31:0] pred_next;
    logic [31:0] actual;
    logic        pred_taken;
    logic        fetching;
    logic        resolve;
    logic        redirect;
    logic        advance;
    logic        push;
    logic        q_full;
    logic        q_empty;
    logic        unused_head_taken;
    pred_entry_t entry;
    pred_entry_t head;

    assign pc4        = pc_q + 32'd4;
    assign pred_taken = bht_taken & btb_hit;

    next_pc_mux #(.WIDTH(32)) u_mux (
        .sel    (pred_taken),
        .seq    (pc4),
        .target (btb_target),
        .next   (pred_next)
    );

    assign entry = '{pred_taken: pred_taken, pred_next: pred_next, pc4: pc4};

    pred_queue #(.DEPTH(PQ_DEPTH)) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (resolve),
        .clear   (redirect),
        .din     (entry),
        .dout    (head),
        .full    (q_full),
        .empty   (q_empty)
    );

    assign unused_head_taken = head.pred_taken;

    assign resolve  = ex_valid & ~q_empty;
    assign actual   = ex_taken ? ex_target : head.pc4;
    assign redirect = resolve & (actual != head.pred_next);

    assign fetching = (state_q == ST_RUN) | (state_q == ST_HOLD);
    // A same-cycle pop frees a slot, so a full queue only blocks without one.
    assign advance  = fetching & ~stall & imem_ready
                    & ~(is_branch & q_full & ~resolve);
    assign push     = advance & is_branch & ~redirect;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN,
            ST_HOLD: begin
                state_d = advance ? ST_RUN : ST_HOLD;
                if (advance) pc_d = pred_next;
            end
            ST_REDIR: state_d = ST_RUN;
        endcase
        if (redirect) begin
            state_d = ST_REDIR;
            pc_d    = actual;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = fetching;
    assign flush       = redirect;
    assign mispredict  = redirect;
    assign pq_full     = q_full;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && ex_valid)
            assert (!q_empty)
            else $error("ex_valid with empty prediction queue");
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven scoreboard bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall, imem_ready, bht_taken, btb_hit, is_branch;
    logic        ex_valid, ex_taken;
    logic [31:0] btb_target, ex_target;
    logic [31:0] pc;
    logic        fetch_valid, flush, pq_full, mispredict;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0), .PQ_DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .bht_taken   (bht_taken),
        .btb_hit     (btb_hit),
        .btb_target  (btb_target),
        .is_branch   (is_branch),
        .ex_valid    (ex_valid),
        .ex_taken    (ex_taken),
        .ex_target   (ex_target),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .pq_full     (pq_full),
        .mispredict  (mispredict)
    );

    typedef struct {
        logic        stall, ready, bht, hit;
        logic [31:0] tgt;
        logic        br, exv, ext;
        logic [31:0] extgt;
        logic [31:0] pc;
        logic        fv, fl, mp, full;
        int          cnt;
    } vec_t;

    typedef struct {
        int          row;
        logic [31:0] pc;
        logic        fv, fl, mp, full;
        int          cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic st, input logic rd, input logic bt, input logic hi,
        input logic [31:0] tg, input logic br, input logic ev,
        input logic et, input logic [31:0] etg, input logic [31:0] epc,
        input logic fv, input logic fl, input logic mp, input logic fu,
        input int cnt);
        vec_t v;
        v.stall = st; v.ready = rd; v.bht = bt; v.hit = hi; v.tgt = tg;
        v.br = br; v.exv = ev; v.ext = et; v.extgt = etg;
        v.pc = epc; v.fv = fv; v.fl = fl; v.mp = mp; v.full = fu;
        v.cnt = cnt;
        return v;
    endfunction

    task automatic idle_inputs();
        stall = 0; imem_ready = 1; bht_taken = 0; btb_hit = 0;
        btb_target = 0; is_branch = 0; ex_valid = 0; ex_taken = 0;
        ex_target = 0;
    endtask

    initial begin
        exp_t e;
        //      st rd bt hi tgt           br ev et etgt      pc            fv fl mp fu cnt
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h0,        0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h0,        1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h4,        1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h8,        1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'hC,        1,0,0,0,-1));
        vecs.push_back(mk(1,1,0,0,32'h0,        0,0,0,32'h0,   32'h10,       1,0,0,0,-1));
        vecs.push_back(mk(1,1,0,0,32'h0,        0,0,0,32'h0,   32'h10,       1,0,0,0,-1));
        vecs.push_back(mk(1,1,0,0,32'h0,        0,0,0,32'h0,   32'h10,       1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h10,       1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h14,       1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h18,       1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h1C,       1,0,0,0,-1));
        vecs.push_back(mk(0,1,1,1,32'h100,      1,0,0,32'h0,   32'h20,       1,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,1,1,32'h100, 32'h100,      1,0,0,0,1));
        vecs.push_back(mk(0,1,1,1,32'h20,       0,0,0,32'h0,   32'h104,      1,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,32'h100,      1,0,0,32'h0,   32'h20,       1,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,1,0,32'h0,   32'h100,      1,1,1,0,1));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h24,       0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h24,       1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        1,0,0,32'h0,   32'h28,       1,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,32'h0,        1,0,0,32'h0,   32'h2C,       1,0,0,0,1));
        vecs.push_back(mk(0,1,0,0,32'h0,        1,0,0,32'h0,   32'h30,       1,0,0,0,2));
        vecs.push_back(mk(0,1,0,0,32'h0,        1,0,0,32'h0,   32'h34,       1,0,0,0,3));
        vecs.push_back(mk(0,1,0,0,32'h0,        1,0,0,32'h0,   32'h38,       1,0,0,1,4));
        vecs.push_back(mk(0,1,0,0,32'h0,        1,1,0,32'h0,   32'h38,       1,0,0,1,4));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h3C,       1,0,0,1,4));
        vecs.push_back(mk(1,1,0,0,32'h0,        1,1,1,32'h200, 32'h40,       1,1,1,1,4));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'h200,      0,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,32'hFFFF_FFFC,0,0,0,32'h0,   32'h200,      1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,0,0,32'h0,   32'hFFFF_FFFC,1,0,0,0,-1));
        vecs.push_back(mk(0,1,0,0,32'h0,        1,0,0,32'h0,   32'h0,        1,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,32'h0,        0,1,1,32'h80,  32'h4,        1,1,1,0,1));

        idle_inputs();
        @(posedge clk); #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", 32'(fetch_valid), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_misp", 32'(mispredict), 32'h0);
        @(posedge clk); #1;
        reset_n = 1;

        foreach (vecs[i]) begin
            stall      = vecs[i].stall;
            imem_ready = vecs[i].ready;
            bht_taken  = vecs[i].bht;
            btb_hit    = vecs[i].hit;
            btb_target = vecs[i].tgt;
            is_branch  = vecs[i].br;
            ex_valid   = vecs[i].exv;
            ex_taken   = vecs[i].ext;
            ex_target  = vecs[i].extgt;
            sb.push_back('{row: i, pc: vecs[i].pc, fv: vecs[i].fv,
                           fl: vecs[i].fl, mp: vecs[i].mp,
                           full: vecs[i].full, cnt: vecs[i].cnt});
            #1;
            e = sb.pop_front();
            chk($sformatf("r%0d_pc", e.row), pc, e.pc);
            chk($sformatf("r%0d_fv", e.row), 32'(fetch_valid), 32'(e.fv));
            chk($sformatf("r%0d_flush", e.row), 32'(flush), 32'(e.fl));
            chk($sformatf("r%0d_misp", e.row), 32'(mispredict), 32'(e.mp));
            chk($sformatf("r%0d_full", e.row), 32'(pq_full), 32'(e.full));
            if (e.cnt >= 0)
                chk($sformatf("r%0d_cnt", e.row),
                    32'(dut.u_queue.count), 32'(e.cnt));
            @(posedge clk); #1;
        end

        idle_inputs();
        chk("redir_pc", pc, 32'h80);
        chk("redir_fv", 32'(fetch_valid), 32'h0);
        #2 reset_n = 0;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_fv", 32'(fetch_valid), 32'h0);
        chk("async_rst_flush", 32'(flush), 32'h0);
        chk("async_rst_cnt", 32'(dut.u_queue.count), 32'h0);
        @(posedge clk); #1;
        chk("held_rst_pc", pc, 32'h0);
        reset_n = 1;
        #1;
        chk("boot_pc", pc, 32'h0);
        chk("boot_fv", 32'(fetch_valid), 32'h0);
        @(posedge clk); #1;
        chk("run_pc", pc, 32'h0);
        chk("run_fv", 32'(fetch_valid), 32'h1);
        @(posedge clk); #1;
        chk("run_pc4", pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
